// File: rtl/key_scan_arbiter.sv
// Shared-timer debouncer: a round-robin scanner locks one debounce counter onto
// the first key whose synchronized level differs from its committed level.
module key_scan_arbiter #(
  parameter int NUM_KEYS        = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int PTR_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                busy,
  output logic [PTR_W-1:0]    cur_key,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    FILTER = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] LAST_KEY = PTR_W'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  state_t              state, state_n;
  logic [PTR_W-1:0]    ptr, ptr_n, ptr_inc;
  logic                target, target_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic [NUM_KEYS-1:0] level_n, press_n, release_n;
  logic [NUM_KEYS-1:0] sync1, sync2;

  // Two-flop synchronizer; only sync2 feeds any decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign ptr_inc = (ptr == LAST_KEY) ? '0 : ptr + 1'b1;
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      ptr         <= '0;
      target      <= 1'b0;
      cnt         <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      target      <= target_n;
      cnt         <= cnt_n;
      key_level   <= level_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  end

  // Pulses default to zero, so a COMMIT cycle always clears them on exit.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    target_n  = target;
    cnt_n     = cnt;
    level_n   = key_level;
    press_n   = '0;
    release_n = '0;
    case (state)
      SCAN: begin
        if (sync2[ptr] != key_level[ptr]) begin
          target_n = sync2[ptr];
          cnt_n    = CNT_W'(1);
          state_n  = FILTER;
        end else begin
          ptr_n = ptr_inc;
        end
      end
      FILTER: begin
        if (sync2[ptr] != target) begin
          // Bounce: give up and move on so this key cannot starve the rest.
          cnt_n   = '0;
          ptr_n   = ptr_inc;
          state_n = SCAN;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == DB_LIMIT) begin
            level_n[ptr]   = target;
            press_n[ptr]   = target;
            release_n[ptr] = ~target;
            state_n        = COMMIT;
          end
        end
      end
      COMMIT: begin
        ptr_n   = ptr_inc;
        cnt_n   = '0;
        state_n = SCAN;
      end
      default: begin
        cnt_n   = '0;
        state_n = SCAN;
      end
    endcase
  end

  assign busy      = (state != SCAN);
  assign cur_key   = ptr;
  assign dbg_state = state;

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Bench for key_scan_arbiter: pulse events are captured by a monitor and
// matched in order against expectations queued when each stimulus is driven.
module tb_key_scan_arbiter;

  localparam int NK = 4;
  localparam int CW = 4;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          busy;
  logic [1:0]    cur_key;
  logic [1:0]    dbg_state;

  typedef struct {
    int            cyc;
    logic [2*NK-1:0] ev;
  } obs_t;

  logic [2*NK-1:0] exp_q[$];
  obs_t            obs_q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;

  key_scan_arbiter #(.NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .busy(busy),
    .cur_key(cur_key), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every cycle that carries any pulse bit.
  always @(negedge clk) begin
    obs_t o;
    if ((key_press | key_release) != '0) begin
      o.cyc = cyc;
      o.ev  = {key_release, key_press};
      obs_q.push_back(o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int budget);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_scan_at(input logic [1:0] k, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cur_key == k && !busy) found = 1'b1;
    end
  endtask

  function automatic logic [2*NK-1:0] press_ev(input int k);
    logic [2*NK-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [2*NK-1:0] release_ev(input int k);
    logic [2*NK-1:0] v;
    v = '0;
    v[k+NK] = 1'b1;
    return v;
  endfunction

  // Pops n expected events; pulse i must land in cycle first_cyc + i*step.
  task automatic expect_events(input string name, input int n, input int first_cyc,
                               input int step);
    logic [2*NK-1:0] e;
    obs_t o;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      wait_obs(60);
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: no pulse seen, required ev=%b", name, i, e);
      end else begin
        o = obs_q.pop_front();
        if (o.ev !== e) begin
          errors++;
          $display("FAIL %s[%0d]: ev=%b required %b", name, i, o.ev, e);
        end
        checks++;
        if (o.cyc !== first_cyc + i * step) begin
          errors++;
          $display("FAIL %s_time[%0d]: cycle %0d required %0d", name, i, o.cyc,
                   first_cyc + i * step);
        end
      end
    end
  endtask

  task automatic test_reset();
    int e;
    bit found;
    rst = 1'b1;
    key_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({key_level, key_press, key_release, busy, cur_key, dbg_state} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: lvl=%b prs=%b rel=%b busy=%b cur=%0d st=%0d required all 0",
                 i, key_level, key_press, key_release, busy, cur_key, dbg_state);
      end
    end
    e = cyc;
    rst = 1'b0;
    // While the synchronizer fills, the scanner walks past keys 0 and 1.
    for (int i = 0; i < 4; i++) exp_q.push_back(press_ev((i + 2) % NK));
    expect_events("reset_press", 4, e + 10, DB + 1);
    checks++;
    if (key_level !== 4'b1111) begin
      errors++;
      $display("FAIL reset_level: key_level=%b required 1111", key_level);
    end
    wait_scan_at(2'd2, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL release_all_sync: scanner never idle at key 2");
    end
    e = cyc;
    key_in = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q.push_back(release_ev(i));
    expect_events("release_all", 4, e + 10, DB + 1);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("FAIL release_all_level: key_level=%b required 0000", key_level);
    end
  endtask

  task automatic test_clean_press();
    int t0;
    t0 = -1;
    key_in[2] = 1'b1;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      tick();
      if (busy) t0 = cyc;
    end
    checks++;
    if (t0 < 0) begin
      errors++;
      $display("FAIL press_busy: busy never rose, required 1");
      return;
    end
    checks++;
    if (cur_key !== 2'd2) begin
      errors++;
      $display("FAIL press_cur_key: cur_key=%0d required 2", cur_key);
    end
    exp_q.push_back(press_ev(2));
    expect_events("clean_press", 1, t0 + DB - 1, 0);
    checks++;
    if (busy !== 1'b1 || key_level !== 4'b0100) begin
      errors++;
      $display("FAIL press_commit: busy=%b lvl=%b required 1/0100", busy, key_level);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL press_busy_fall: busy=%b required 0", busy);
    end
  endtask

  task automatic test_bounce();
    bit seen;
    seen = 1'b0;
    tick();
    key_in[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= busy;
    end
    key_in[1] = 1'b0;
    tick();
    seen |= busy;
    tick();
    seen |= busy;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bounce_filter: busy=0 throughout, required a FILTER period");
    end
    tick();
    checks++;
    if (busy !== 1'b0 || cur_key !== 2'd2) begin
      errors++;
      $display("FAIL bounce_reject: busy=%b cur=%0d required 0/2", busy, cur_key);
    end
    repeat (20) tick();
    checks++;
    if (obs_q.size() != 0 || key_level !== 4'b0100) begin
      errors++;
      $display("FAIL bounce_quiet: pulses=%0d lvl=%b required 0/0100", obs_q.size(), key_level);
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    int c;
    wait_scan_at(2'd2, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_sync: scanner never idle at key 2");
    end
    c = cyc;
    key_in = 4'b1101;
    exp_q.push_back(press_ev(0));
    exp_q.push_back(press_ev(3));
    expect_events("simul_press", 2, c + 10, DB + 3);
    checks++;
    if (key_level !== 4'b1101) begin
      errors++;
      $display("FAIL simul_level: key_level=%b required 1101", key_level);
    end
  endtask

  task automatic test_release();
    obs_t o;
    key_in = 4'b1001;
    exp_q.push_back(release_ev(2));
    wait_obs(60);
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL release2: no pulse seen, required ev=%b", release_ev(2));
      void'(exp_q.pop_front());
    end else begin
      o = obs_q.pop_front();
      if (o.ev !== exp_q.pop_front()) begin
        errors++;
        $display("FAIL release2: ev=%b required %b", o.ev, release_ev(2));
      end
    end
    repeat (20) tick();
    checks++;
    if (obs_q.size() != 0 || key_level !== 4'b1001) begin
      errors++;
      $display("FAIL release_after: pulses=%0d lvl=%b required 0/1001", obs_q.size(), key_level);
    end
  endtask

  task automatic test_reset_mid_filter();
    bit found;
    int e;
    found = 1'b0;
    key_in = 4'b1011;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (busy && cur_key == 2'd1) found = 1'b1;
    end
    tick();
    tick();
    checks++;
    if (!found || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_filter: found=%b busy=%b required 1/1", found, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({key_level, key_press, key_release, busy, cur_key} !== '0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_outputs: lvl=%b prs=%b rel=%b busy=%b cur=%0d pulses=%0d required all 0",
               key_level, key_press, key_release, busy, cur_key, obs_q.size());
    end
    e = cyc;
    rst = 1'b0;
    exp_q.push_back(press_ev(3));
    exp_q.push_back(press_ev(0));
    exp_q.push_back(press_ev(1));
    expect_events("midrst_press", 3, e + 11, DB + 1);
    checks++;
    if (key_level !== 4'b1011) begin
      errors++;
      $display("FAIL midrst_level: key_level=%b required 1011", key_level);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_filter();
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: obs=%0d exp=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
